// File: rtl/note_lane_scheduler_if.sv
// note_lane_scheduler_if: frame, spawn, pixel-query and status signals of the note lane scheduler.
// master drives frame/spawn/pixel inputs; slave is the scheduler.
interface note_lane_scheduler_if #(parameter int SLOTS = 4);
    logic             frame_tick;
    logic             spawn_valid;
    logic [1:0]       spawn_lane;
    logic             spawn_ready;
    logic [9:0]       px;
    logic [8:0]       py;
    logic             hit;
    logic [1:0]       hit_color;
    logic [11:0]      sprite_addr;
    logic             miss_pulse;
    logic [1:0]       miss_lane;
    logic [SLOTS-1:0] live_mask;
    modport master (
        output frame_tick, spawn_valid, spawn_lane, px, py,
        input  spawn_ready, hit, hit_color, sprite_addr, miss_pulse, miss_lane, live_mask
    );
    modport slave (
        input  frame_tick, spawn_valid, spawn_lane, px, py,
        output spawn_ready, hit, hit_color, sprite_addr, miss_pulse, miss_lane, live_mask
    );
endinterface

// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler: note slot pool with per-frame advance/retire and registered sprite-ROM pixel arbitration.
// Optional NOTE_SCHED_AUTOSPAWN_EN adds LFSR-driven spawns every SPAWN_PERIOD frames.
module note_lane_scheduler #(
    parameter int SLOTS        = 4,
    parameter int LANE_PITCH   = 80,
    parameter int SPRITE_SIZE  = 51,
    parameter int SCREEN_H     = 480,
    parameter int SPEED        = 1,
    parameter int SPAWN_PERIOD = 60
) (
    input logic                  clk,
    input logic                  reset,
    note_lane_scheduler_if.slave bus
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [1:0]       lane_q [SLOTS];
    logic [1:0]       lane_d [SLOTS];
    logic [9:0]       y_q [SLOTS];
    logic [9:0]       y_d [SLOTS];
    logic             hit_q, hit_d;
    logic [1:0]       hit_color_q, hit_color_d;
    logic [11:0]      sprite_addr_q, sprite_addr_d;
    logic             miss_pulse_q, miss_pulse_d;
    logic [1:0]       miss_lane_q, miss_lane_d;
    logic             any_free;
    logic [IW-1:0]    free_idx;
    logic             spawn_go;
    logic [1:0]       spawn_lane_sel;
    logic [9:0]       sx [SLOTS];
    logic [9:0]       pyw;
    logic [10:0]      y_next;

    assign bus.spawn_ready = (state_q == IDLE) && any_free;
    assign bus.hit         = hit_q;
    assign bus.hit_color   = hit_color_q;
    assign bus.sprite_addr = sprite_addr_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.miss_lane   = miss_lane_q;
    assign bus.live_mask   = valid_q;

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

`ifdef NOTE_SCHED_AUTOSPAWN_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        auto_fire;

    // Auto-spawn fires on the frame_tick that completes a period and outranks spawn_valid.
    always_comb begin
        auto_fire      = bus.frame_tick && (frame_cnt_q == 16'(SPAWN_PERIOD - 1));
        frame_cnt_d    = bus.frame_tick ? (auto_fire ? 16'd0 : frame_cnt_q + 16'd1) : frame_cnt_q;
        lfsr_d         = bus.frame_tick ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        spawn_go       = bus.spawn_ready && (auto_fire || bus.spawn_valid);
        spawn_lane_sel = auto_fire ? lfsr_q[1:0] : bus.spawn_lane;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q      <= 16'hACE1;
            frame_cnt_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    always_comb begin
        spawn_go       = bus.spawn_ready && bus.spawn_valid;
        spawn_lane_sel = bus.spawn_lane;
    end
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        valid_d      = valid_q;
        lane_d       = lane_q;
        y_d          = y_q;
        miss_pulse_d = 1'b0;
        miss_lane_d  = miss_lane_q;
        y_next       = {1'b0, y_q[idx_q]} + 11'(SPEED);
        if (state_q == IDLE) begin
            // Spawn lands before the pass starts so a same-cycle tick also advances it.
            if (spawn_go) begin
                valid_d[free_idx] = 1'b1;
                lane_d[free_idx]  = spawn_lane_sel;
                y_d[free_idx]     = '0;
            end
            if (bus.frame_tick || pending_q) begin
                state_d   = UPDATE;
                idx_d     = '0;
                pending_d = 1'b0;
            end
        end else begin
            if (bus.frame_tick) pending_d = 1'b1;
            if (valid_q[idx_q]) begin
                if (y_next >= 11'(SCREEN_H)) begin
                    valid_d[idx_q] = 1'b0;
                    miss_pulse_d   = 1'b1;
                    miss_lane_d    = lane_q[idx_q];
                end else begin
                    y_d[idx_q] = y_next[9:0];
                end
            end
            idx_d   = idx_q + IW'(1);
            state_d = (idx_q == IW'(SLOTS - 1)) ? IDLE : UPDATE;
        end
    end

    always_comb begin
        pyw           = {1'b0, bus.py};
        hit_d         = 1'b0;
        hit_color_d   = '0;
        sprite_addr_d = '0;
        // Walk from the top index down so the lowest matching slot is written last and wins.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            sx[i] = 10'(32'(lane_q[i]) * LANE_PITCH);
            if (valid_q[i] && sx[i] < bus.px && bus.px < sx[i] + 10'(SPRITE_SIZE)
                && y_q[i] < pyw && pyw < y_q[i] + 10'(SPRITE_SIZE)) begin
                hit_d         = 1'b1;
                hit_color_d   = lane_q[i];
                sprite_addr_d = 12'(bus.px - sx[i]) + 12'(pyw - y_q[i]) * 12'(SPRITE_SIZE);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            valid_q       <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                lane_q[i] <= '0;
                y_q[i]    <= '0;
            end
            hit_q         <= 1'b0;
            hit_color_q   <= '0;
            sprite_addr_q <= '0;
            miss_pulse_q  <= 1'b0;
            miss_lane_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            valid_q       <= valid_d;
            lane_q        <= lane_d;
            y_q           <= y_d;
            hit_q         <= hit_d;
            hit_color_q   <= hit_color_d;
            sprite_addr_q <= sprite_addr_d;
            miss_pulse_q  <= miss_pulse_d;
            miss_lane_q   <= miss_lane_d;
        end
    end
endmodule
